// File: rtl/xoodoo_perm.sv
// Iterative Xoodoo permutation core: one round per clock over a 384-bit
// working register, returning the permuted state with a one-cycle pulse.
module xoodoo_perm #(
  parameter int NROUNDS = 12
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [383:0] state_in,
  output logic [383:0] state_out,
  output logic         complete,
  output logic         busy
);

  localparam int RW = $clog2(NROUNDS + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS - 1);
  localparam logic [3:0] RC_BASE = 4'(12 - NROUNDS);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t          fsm_reg, fsm_next;
  logic [RW-1:0] round_reg, round_next;
  logic [383:0]  work_reg, work_next;
  logic [383:0]  out_reg, out_next;
  logic          complete_reg, complete_next;
  logic          busy_reg, busy_next;

  logic [383:0]  round_out;
  logic [31:0]   rc;
  logic [3:0]    rc_idx;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Round-constant table; the run uses its last NROUNDS entries.
  function automatic logic [31:0] rc_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'h0000_0058;
      4'd1:    return 32'h0000_0038;
      4'd2:    return 32'h0000_03C0;
      4'd3:    return 32'h0000_00D0;
      4'd4:    return 32'h0000_0120;
      4'd5:    return 32'h0000_0014;
      4'd6:    return 32'h0000_0060;
      4'd7:    return 32'h0000_002C;
      4'd8:    return 32'h0000_0380;
      4'd9:    return 32'h0000_00F0;
      4'd10:   return 32'h0000_01A0;
      4'd11:   return 32'h0000_0012;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign rc_idx = RC_BASE + 4'(round_reg);
  assign rc     = rc_lookup(rc_idx);

  // Lanes of the three planes at each stage of the round.
  logic [31:0] a0 [4], a1 [4], a2 [4];
  logic [31:0] p [4], e [4];
  logic [31:0] w0 [4], w1 [4], w2 [4];
  logic [31:0] c0 [4], c1 [4], c2 [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign a0[gi] = work_reg[32*gi       +: 32];
      assign a1[gi] = work_reg[128 + 32*gi +: 32];
      assign a2[gi] = work_reg[256 + 32*gi +: 32];
      // theta column parity and its effect on lane x (taken from column x-1)
      assign p[gi] = a0[gi] ^ a1[gi] ^ a2[gi];
      assign e[gi] = rotl(p[(gi+3)%4], 5) ^ rotl(p[(gi+3)%4], 14);
      // theta folded into rho-west: plane 1 shifts by one lane, plane 2 rotates
      if (gi == 0) begin : g_iota
        assign w0[gi] = a0[gi] ^ e[gi] ^ rc;
      end else begin : g_no_iota
        assign w0[gi] = a0[gi] ^ e[gi];
      end
      assign w1[gi] = a1[(gi+3)%4] ^ e[(gi+3)%4];
      assign w2[gi] = rotl(a2[gi] ^ e[gi], 11);
      // chi on the west-shifted planes
      assign c0[gi] = w0[gi] ^ (~w1[gi] & w2[gi]);
      assign c1[gi] = w1[gi] ^ (~w2[gi] & w0[gi]);
      assign c2[gi] = w2[gi] ^ (~w0[gi] & w1[gi]);
      // rho-east and repack
      assign round_out[32*gi       +: 32] = c0[gi];
      assign round_out[128 + 32*gi +: 32] = rotl(c1[gi], 1);
      assign round_out[256 + 32*gi +: 32] = rotl(c2[(gi+2)%4], 8);
    end
  endgenerate

  // Next-state logic: accept in IDLE, one round per cycle in RUN.
  always_comb begin
    fsm_next      = fsm_reg;
    round_next    = round_reg;
    work_next     = work_reg;
    out_next      = out_reg;
    complete_next = 1'b0;
    busy_next     = busy_reg;
    case (fsm_reg)
      IDLE: begin
        if (start) begin
          work_next  = state_in;
          round_next = '0;
          fsm_next   = RUN;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        work_next = round_out;
        if (round_reg == LAST_ROUND) begin
          out_next      = round_out;
          complete_next = 1'b1;
          busy_next     = 1'b0;
          round_next    = '0;
          fsm_next      = IDLE;
        end else begin
          round_next = round_reg + 1'b1;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // State registers with asynchronous abort on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_reg      <= IDLE;
      round_reg    <= '0;
      work_reg     <= '0;
      out_reg      <= '0;
      complete_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      fsm_reg      <= fsm_next;
      round_reg    <= round_next;
      work_reg     <= work_next;
      out_reg      <= out_next;
      complete_reg <= complete_next;
      busy_reg     <= busy_next;
    end
  end

  assign state_out = out_reg;
  assign complete  = complete_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_xoodoo_perm.sv
// Directed testbench for xoodoo_perm: 12-round core plus a 1-round instance.
module tb_xoodoo_perm;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, start1;
  logic [383:0] state_in, state_in1;
  logic [383:0] state_out, state_out1;
  logic         complete, complete1, busy, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xoodoo_perm #(.NROUNDS(12)) dut (
    .clk(clk), .resetn(resetn), .start(start), .state_in(state_in),
    .state_out(state_out), .complete(complete), .busy(busy)
  );

  xoodoo_perm #(.NROUNDS(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .state_in(state_in1),
    .state_out(state_out1), .complete(complete1), .busy(busy1)
  );

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Reference Xoodoo[nr] on a plane/lane array, step by step.
  function automatic logic [383:0] model(input logic [383:0] s, input int nr);
    logic [31:0] rct [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                              32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};
    logic [31:0] a [3][4];
    logic [31:0] b [3][4];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [383:0] o;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        a[y][x] = s[128*y + 32*x +: 32];
    for (int r = 12 - nr; r < 12; r++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
      b = a;
      for (int x = 0; x < 4; x++) begin
        a[1][x] = b[1][(x+3)%4];
        a[2][x] = rl(b[2][x], 11);
      end
      a[0][0] = a[0][0] ^ rct[r];
      b = a;
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++)
          a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
      b = a;
      for (int x = 0; x < 4; x++) begin
        a[1][x] = rl(b[1][x], 1);
        a[2][x] = rl(b[2][(x+2)%4], 8);
      end
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        o[128*y + 32*x +: 32] = a[y][x];
    return o;
  endfunction

  function automatic logic [383:0] rnd384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Stimulus driver: one accepted run on the 12-round core, observed for a
  // bounded window; reports latency, busy cycles, pulse count and result.
  task automatic run12(input logic [383:0] s, output int lat, output int busy_cnt,
                       output int pulses, output logic [383:0] res);
    lat = -1; busy_cnt = 0; pulses = 0; res = '0;
    state_in = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (complete) begin
        pulses++;
        if (lat < 0) begin lat = cyc; res = state_out; end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; start1 = 1'b0; state_in = '0; state_in1 = '0;
    @(posedge clk); #1;
    total++; if (state_out !== 384'd0) begin bad++; $display("FAIL reset_state_out got %h want 0", state_out); end
    total++; if (complete !== 1'b0) begin bad++; $display("FAIL reset_complete got %b want 0", complete); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (state_out1 !== 384'd0 || busy1 !== 1'b0 || complete1 !== 1'b0) begin
      bad++; $display("FAIL reset_dut1 busy=%b complete=%b want 0,0 state_out nonzero=%b", busy1, complete1, |state_out1);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    $display("reset: outputs checked");
  endtask

  task automatic test_one_round();
    logic [383:0] exp;
    int lat;
    logic [383:0] res;
    exp = '0; exp[31:0] = 32'h0000_0012; exp[159:128] = 32'h0000_0024;
    lat = -1; res = '0;
    state_in1 = '0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      if (complete1 && lat < 0) begin lat = cyc; res = state_out1; end
    end
    total++; if (lat != 1) begin bad++; $display("FAIL one_round_latency got %0d want 1", lat); end
    total++; if (res !== exp) begin bad++; $display("FAIL one_round_result got %h want %h", res, exp); end
    $display("one_round: latency=%0d lane0=%h lane4=%h", lat, res[31:0], res[159:128]);
  endtask

  task automatic test_zero_state();
    int lat, bc, pc;
    logic [383:0] res, exp;
    exp = model('0, 12);
    run12('0, lat, bc, pc, res);
    total++; if (lat != 12) begin bad++; $display("FAIL zero_latency got %0d want 12", lat); end
    total++; if (bc != 12) begin bad++; $display("FAIL zero_busy_cycles got %0d want 12", bc); end
    total++; if (pc != 1) begin bad++; $display("FAIL zero_pulses got %0d want 1", pc); end
    total++; if (res !== exp) begin bad++; $display("FAIL zero_result got %h want %h", res, exp); end
    total++; if (state_out !== exp) begin bad++; $display("FAIL zero_hold got %h want %h", state_out, exp); end
    $display("zero_state: latency=%0d busy=%0d lane0=%h", lat, bc, res[31:0]);
  endtask

  task automatic test_random();
    int lat, bc, pc;
    logic [383:0] s, res, exp;
    for (int i = 0; i < 20; i++) begin
      s = rnd384();
      exp = model(s, 12);
      run12(s, lat, bc, pc, res);
      total++; if (lat != 12 || pc != 1) begin bad++; $display("FAIL random%0d_timing lat=%0d pulses=%0d want 12,1", i, lat, pc); end
      total++; if (res !== exp) begin bad++; $display("FAIL random%0d_result got %h want %h", i, res, exp); end
      $display("random %0d: in=%h.. out=%h..", i, s[383:352], res[383:352]);
    end
  endtask

  task automatic test_restart_ignored();
    logic [383:0] s, exp, res;
    int lat, pc;
    s = rnd384(); exp = model(s, 12); lat = -1; pc = 0; res = '0;
    state_in = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 3 || cyc == 7) begin start = 1'b1; state_in = rnd384(); end
      else start = 1'b0;
      @(posedge clk); #1;
      if (complete) begin pc++; if (lat < 0) begin lat = cyc; res = state_out; end end
    end
    start = 1'b0;
    total++; if (pc != 1 || lat != 12) begin bad++; $display("FAIL restart_pulses got %0d at %0d want 1 at 12", pc, lat); end
    total++; if (res !== exp) begin bad++; $display("FAIL restart_result got %h want %h", res, exp); end
    $display("restart_ignored: pulses=%0d latency=%0d", pc, lat);
  endtask

  task automatic test_reset_mid_run();
    logic [383:0] s, exp, res;
    int pc, lat, bc;
    s = rnd384(); exp = model(s, 12); pc = 0;
    state_in = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || complete !== 1'b0) begin bad++; $display("FAIL midreset_flags busy=%b complete=%b want 0,0", busy, complete); end
    total++; if (state_out !== 384'd0) begin bad++; $display("FAIL midreset_state_out got %h want 0", state_out); end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (complete) pc++;
    end
    total++; if (pc != 0) begin bad++; $display("FAIL midreset_no_complete got %0d pulses want 0", pc); end
    run12(s, lat, bc, pc, res);
    total++; if (lat != 12 || res !== exp) begin bad++; $display("FAIL midreset_rerun lat=%0d got %h want 12 %h", lat, res, exp); end
    $display("reset_mid_run: rerun latency=%0d", lat);
  endtask

  task automatic test_back_to_back();
    logic [383:0] ins [46];
    int times [$];
    logic [383:0] outs [$];
    int want_t [3] = '{12, 25, 38};
    int want_i [3] = '{0, 13, 26};
    for (int cyc = 0; cyc < 46; cyc++) begin
      start = (cyc < 40);
      state_in = rnd384();
      ins[cyc] = state_in;
      @(posedge clk); #1;
      if (complete) begin times.push_back(cyc); outs.push_back(state_out); end
    end
    start = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin @(posedge clk); #1; end
    total++; if (times.size() != 3) begin bad++; $display("FAIL b2b_count got %0d want 3", times.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < times.size()) begin
        total++; if (times[k] != want_t[k]) begin bad++; $display("FAIL b2b_time%0d got %0d want %0d", k, times[k], want_t[k]); end
        total++; if (outs[k] !== model(ins[want_i[k]], 12)) begin
          bad++; $display("FAIL b2b_result%0d got %h want %h", k, outs[k], model(ins[want_i[k]], 12));
        end
        $display("back_to_back run %0d: complete at %0d", k, times[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_round();
    test_zero_state();
    test_random();
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
